// File: rtl/pwm16bits_capture_if.sv
// pwm16bits_capture_if: control inputs and measurement results of the PWM capture block
interface pwm16bits_capture_if;
    logic        ce;
    logic        en;
    logic        invert;
    logic [15:0] timeout_max;
    logic        pwm_in;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    modport master (
        output ce, en, invert, timeout_max, pwm_in,
        input  period, high_time, meas_valid, locked, timeout
    );

    modport slave (
        input  ce, en, invert, timeout_max, pwm_in,
        output period, high_time, meas_valid, locked, timeout
    );
endinterface

// File: rtl/pwm16bits_capture.sv
// pwm16bits_capture: measures period and high time of an asynchronous PWM input in ce ticks
module pwm16bits_capture (
    input logic                 clk,
    input logic                 rst,
    pwm16bits_capture_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, sig_q, sig_d;
    logic [15:0] cnt_q, cnt_d, hi_q, hi_d, period_q, period_d, high_q, high_d;
    logic        valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
    logic        sig, rise, fall, to_hit;
    logic [16:0] sum;
    logic [15:0] cnt_inc;

    assign sig     = sync2_q ^ bus.invert;
    assign rise    = sig & ~sig_q;
    assign fall    = ~sig & sig_q;
    assign sum     = {1'b0, cnt_q} + {16'd0, bus.ce};
    assign cnt_inc = sum[16] ? 16'hFFFF : sum[15:0];
    assign to_hit  = (bus.timeout_max != 16'd0) && (cnt_q >= bus.timeout_max);

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.meas_valid = valid_q;
    assign bus.locked     = locked_q;
    assign bus.timeout    = timeout_q;

    // Synchronizer, edge history, measurement FSM and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sig_q     <= 1'b0;
            cnt_q     <= 16'd0;
            hi_q      <= 16'd0;
            period_q  <= 16'd0;
            high_q    <= 16'd0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state: edges win over timeout; a full period is published only on the closing rise
    always_comb begin
        sync1_d   = bus.pwm_in;
        sync2_d   = sync1_q;
        sig_d     = sig;
        state_d   = state_q;
        cnt_d     = cnt_inc;
        hi_d      = hi_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        if (!bus.en) begin
            state_d  = IDLE;
            cnt_d    = 16'd0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = 16'd0;
                    state_d = rise ? HIGH : IDLE;
                end
                HIGH: begin
                    if (fall) begin
                        hi_d    = cnt_inc;
                        state_d = LOW;
                    end else if (to_hit) begin
                        state_d   = IDLE;
                        cnt_d     = 16'd0;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d  = cnt_inc;
                        high_d    = hi_q;
                        valid_d   = 1'b1;
                        locked_d  = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = 16'd0;
                        state_d   = HIGH;
                    end else if (to_hit) begin
                        state_d   = IDLE;
                        cnt_d     = 16'd0;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end
endmodule
